// File: rtl/snn_pkg.sv
// Shared widths and state encoding for the spiking-neuron blocks
// (LIF, STDP and the spike-rate decoder).
package snn_pkg;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; o_next exposes the value the
// counter would take this cycle without the clear, so callers can use it.
module sat_counter
    import snn_pkg::*;
#(
    parameter int             W   = CNT_W,
    parameter logic [W-1:0]   MAX = W'(CNT_MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_q;

    assign o_next = (i_inc && (r_q != MAX)) ? r_q + W'(1) : r_q;
    assign o_q    = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else begin
            r_q <= o_next;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a neuron spike train into per-window spike counts and the latest
// inter-spike interval, presented on a valid/ready result register.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = snn_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] window_len,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate_count,
    output logic [CNT_W-1:0] last_isi,
    output logic             overrun
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_first;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_win_len;
    logic [CNT_W-1:0] w_len;
    logic             w_win_end;
    logic             w_spike;
    logic             r_seen;
    logic [CNT_W-1:0] r_isi;
    logic [CNT_W-1:0] w_isi_final;
    logic [CNT_W-1:0] w_spk_q;
    logic [CNT_W-1:0] w_spk_next;
    logic [CNT_W-1:0] w_isi_cnt_q;
    logic [CNT_W-1:0] w_isi_cnt_next;
    logic             w_load;
    logic             r_valid;
    logic [CNT_W-1:0] r_rate;
    logic [CNT_W-1:0] r_last_isi;
    logic             r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_first      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_next = RUN;
                    w_first      = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The first window's length is not registered yet on its cycle 0.
    assign w_len     = w_first ? window_len : r_win_len;
    assign w_win_end = en && (r_win_cnt == w_len);
    assign w_spike   = en && spike_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_win_len <= '0;
        end else begin
            if (!en || w_win_end) begin
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
            if (w_first || w_win_end) begin
                r_win_len <= window_len;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_spk_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!en || w_win_end),
        .i_inc  (w_spike),
        .o_q    (w_spk_q),
        .o_next (w_spk_next)
    );

    sat_counter #(.W(CNT_W)) u_isi_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!en || w_spike),
        .i_inc  (en),
        .o_q    (w_isi_cnt_q),
        .o_next (w_isi_cnt_next)
    );

    assign w_isi_final = (w_spike && r_seen) ? w_isi_cnt_next : r_isi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= 1'b0;
            r_isi  <= '0;
        end else if (!en) begin
            r_seen <= 1'b0;
            r_isi  <= '0;
        end else if (w_spike) begin
            r_seen <= 1'b1;
            r_isi  <= w_isi_final;
        end
    end

    // A full register may still take a new result if it drains this cycle.
    assign w_load = w_win_end && (!r_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rate     <= '0;
            r_last_isi <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_rate     <= w_spk_next;
                r_last_isi <= w_isi_final;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (!en) begin
                r_overrun <= 1'b0;
            end else if (w_win_end && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign rate_count = r_rate;
    assign last_isi   = r_last_isi;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised and directed bench for spike_rate_decoder against a time-stamp
// based reference model of windows, spike times and the result slot.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] rate_count;
    logic [7:0] last_isi;
    logic       overrun;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .rate_count (rate_count),
        .last_isi   (last_isi),
        .overrun    (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle numbers for window start and spikes.
    int t = 0;
    bit m_active = 0;
    int m_start = 0;
    int m_len = 0;
    int m_cnt = 0;
    int m_nspk = 0;
    int m_last = 0;
    int m_prev = 0;
    bit m_valid = 0;
    bit m_ovr = 0;
    int m_rate = 0;
    int m_isi = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0d want %0d", tag, t, obs, exp);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input bit e, input bit s, input bit [7:0] wl, input bit r);
        bit wend;
        wend = 0;
        if (!e) begin
            m_active = 0;
            m_nspk   = 0;
            m_ovr    = 0;
        end else begin
            if (!m_active) begin
                m_active = 1;
                m_start  = t;
                m_len    = int'(wl);
                m_cnt    = 0;
            end
            if (s) begin
                m_cnt++;
                m_prev = m_last;
                m_last = t;
                m_nspk++;
            end
            wend = ((t - m_start) == m_len);
        end
        if (m_valid && r) begin
            $display("xfer t=%0d rate=%0d isi=%0d", t, m_rate, m_isi);
            m_valid = 0;
        end
        if (wend) begin
            if (!m_valid) begin
                m_valid = 1;
                m_rate  = sat255(m_cnt);
                m_isi   = (m_nspk >= 2) ? sat255(m_last - m_prev) : 0;
            end else begin
                m_ovr = 1;
            end
            m_start = t + 1;
            m_len   = int'(wl);
            m_cnt   = 0;
        end
        t++;
    endtask

    task automatic cyc(input bit e, input bit s, input bit [7:0] wl, input bit r);
        en         = e;
        spike_in   = s;
        window_len = wl;
        out_ready  = r;
        @(posedge clk);
        model_step(e, s, wl, r);
        #1;
        check_val("valid", out_valid, m_valid);
        check_val("overrun", overrun, m_ovr);
        check_val("rate", rate_count, m_rate);
        check_val("isi", last_isi, m_isi);
    endtask

    initial begin
        bit [7:0] wl;
        int dens, rdy_p, len, gap;

        // Reset held with spikes toggling, then idle with en low.
        for (int i = 0; i < 4; i++) begin
            spike_in = i[0];
            @(posedge clk);
        end
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_rate", rate_count, 0);
        check_val("rst_isi", last_isi, 0);
        check_val("rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(0, i[0], 8'd3, 1);

        // Basic rate: spikes on window cycles 2, 5, 9.
        for (int i = 0; i < 10; i++) cyc(1, (i == 2) || (i == 5) || (i == 9), 8'd9, 1);
        check_val("basic_valid", out_valid, 1);
        check_val("basic_rate", rate_count, 3);
        check_val("basic_isi", last_isi, 4);
        cyc(0, 0, 8'd9, 1);

        // Saturation: every cycle of a 256-cycle window is a spike.
        for (int i = 0; i < 256; i++) cyc(1, 1, 8'd255, 1);
        check_val("sat_rate", rate_count, 255);
        check_val("sat_isi", last_isi, 1);
        cyc(0, 0, 8'd255, 1);

        // ISI saturation: two spikes 300 cycles apart.
        for (int i = 0; i < 512; i++) cyc(1, (i == 0) || (i == 300), 8'd255, 1);
        check_val("isi_sat", last_isi, 255);
        cyc(0, 0, 8'd0, 1);

        // Backpressure: second window end must be dropped.
        for (int i = 0; i < 12; i++) cyc(1, i[0], 8'd3, 0);
        check_val("bp_ovr", overrun, 1);
        for (int i = 0; i < 8; i++) cyc(1, i[1], 8'd3, 1);
        cyc(0, 0, 8'd0, 1);

        // Back-to-back single-cycle windows.
        for (int i = 0; i < 20; i++) cyc(1, i[0], 8'd0, 1);
        cyc(0, 0, 8'd9, 0);

        // Abort mid-window with a result pending, then re-enable.
        for (int i = 0; i < 14; i++) cyc(1, (i == 1) || (i == 4), 8'd9, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'd9, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 8'd9, 1);
        for (int i = 0; i < 12; i++) cyc(1, i == 3, 8'd9, 1);
        cyc(0, 0, 8'd9, 1);

        // Randomised enable sessions.
        for (int sess = 0; sess < 40; sess++) begin
            gap = int'($urandom_range(1, 4));
            for (int i = 0; i < gap; i++) cyc(0, 1'($urandom_range(0, 1)), 8'd0, 1'($urandom_range(0, 1)));
            wl    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
            dens  = int'($urandom_range(0, 4));
            rdy_p = int'($urandom_range(0, 4));
            len   = int'($urandom_range(1, 80));
            for (int i = 0; i < len; i++)
                cyc(1, int'($urandom_range(0, 3)) < dens, wl, int'($urandom_range(0, 3)) < rdy_p);
        end

        // Asynchronous reset mid-window aborts everything at once.
        for (int i = 0; i < 11; i++) cyc(1, i[0], 8'd7, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid, 0);
        check_val("arst_rate", rate_count, 0);
        check_val("arst_isi", last_isi, 0);
        check_val("arst_ovr", overrun, 0);
        m_valid  = 0;
        m_rate   = 0;
        m_isi    = 0;
        m_ovr    = 0;
        m_active = 0;
        m_nspk   = 0;
        en       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1, i[1], 8'd4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side decoder for the single-bit spike outputs of the LIF neurons. It converts a spike train back into numbers: a spike count over a programmable window and the most recent inter-spike interval (ISI). It sits downstream of a neuron's spike output and presents each window's result on a valid/ready output register. Readout logic or the STDP debug path can then sample neuron activity without watching every cycle.

## Interface
- CNT_W, 8, width of count, ISI and window-length fields
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  decoder enable; low = idle, counters cleared
- spike_in  input  1  one-cycle spike pulse from a neuron; each high cycle counts as one spike
- window_len  input  CNT_W  window length minus one (window = window_len+1 cycles, 1..256); sampled at window start
- out_ready  input  1  consumer accepts result this cycle
- out_valid  output  1  result register holds an unconsumed result
- rate_count  output  CNT_W  spikes in the completed window, saturating at 255
- last_isi  output  CNT_W  cycles between the last two spikes at window end; 0 = fewer than two spikes since enable; saturates at 255
- overrun  output  1  sticky: a completed window was dropped because the output was full

## Operation
- States: IDLE, RUN. In IDLE with en=0: win_cnt, spk_cnt, isi_cnt, seen cleared; overrun cleared. IDLE→RUN on the first cycle en=1; that cycle is window cycle 0 and latches window_len into win_len_q. RUN→IDLE when en=0. The partial window is discarded, and a pending out_valid result is kept until consumed.
- In RUN each cycle: spk_cnt += spike_in (saturating at 255). win_cnt increments. Window end occurs when win_cnt == win_len_q; then win_cnt←0 and window_len is re-latched.
- A spike in the last window cycle counts in the finishing window. spk_cnt restarts at 0 for the next window, not at the spike.
- ISI: isi_cnt increments every RUN cycle and saturates at 255. On a spike cycle: if seen, isi_q ← sat(isi_cnt+1); then seen←1 and isi_cnt←0. Spikes on consecutive cycles give ISI 1. ISI persists across windows.
- At window end the result is {final spk_cnt including this cycle, isi_q including this cycle's update}.
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, the result loads and out_valid=1.
  - Otherwise the result is dropped and overrun←1.
- Handshake: rate_count and last_isi are stable while out_valid=1. A transfer occurs on a cycle with out_valid & out_ready. With no new load in that cycle, out_valid falls next cycle.

## Timing
- Reset (async): out_valid=0, rate_count=0, last_isi=0, overrun=0, state IDLE.
- Latency: out_valid rises the cycle after the window's last cycle. A window of N cycles starting at cycle t gives out_valid at t+N.
- Throughput: one result per window. With out_ready held high there are no drops even at window_len=0 (a result every cycle).
- Reset asserted mid-window or mid-handshake aborts immediately; nothing is retained.
- A window_len change mid-window takes effect at the next window start only.

## Structure
- Shared package snn_pkg holds CNT_W default, CNT_MAX (255) and the state enum {IDLE, RUN}. The LIF/STDP blocks reuse the widths.
- One sub-module, sat_counter (increment, clear, saturate at max), instanced for spk_cnt and isi_cnt.
- Output register and overrun flag stay in the top module.

## Test plan
- Reset/idle: rst_n low then high with en=0 and spikes toggling → all outputs 0, out_valid never rises.
- Basic rate: window_len=9, en=1, spikes on window cycles 2,5,9, out_ready=1 → out_valid at cycle 10, rate_count=3, last_isi=4.
- Saturation: window_len=255, spike_in held high 256 cycles → rate_count=255, last_isi=1.
- Backpressure: window_len=3, out_ready=0 for 12 cycles → first result held stable, overrun=1 after second window end. Then out_ready=1 → one transfer, and the next window loads normally.
- Back-to-back: window_len=0, out_ready=1, spikes on alternate cycles → out_valid continuously 1, rate_count alternating 1,0, overrun stays 0.
- Abort: en dropped at window cycle 4 of 10 with a pending result → pending result still delivered on out_ready; no partial result; re-enable restarts at cycle 0 with last_isi=0 until two spikes arrive.
